dram_axi_read_master: RTL and testbench

Services the image pipeline's DRAM read requests: accepts one `dram_read_addr/len/en` command, runs it as AXI4 INCR read bursts on the PS DDR port, and streams returned beats back as `dram_read_data/valid`. It signals `dram_read_busy` for the whole transaction. Bursts are split so that none crosses a 4 KB boundary. It sits between the image sender (the request initiator, which writes returned data into its image data buffer FIFO) and the HP AXI interconnect port.

---
 rtl/dram_axi_pkg.sv | 17 +
 rtl/dram_axi_read_master.sv | 158 +++++++++++++++
 tb/tb_dram_axi_read_master.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_axi_pkg.sv
// Shared types and AXI constants for the DRAM read master.
// FSM state encoding, burst/response codes, 4 KB boundary size.
package dram_axi_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [3:0] ARCACHE_DEF = 4'b0011;

  localparam int unsigned BOUNDARY_BYTES = 4096;

endpackage

// File: rtl/dram_axi_read_master.sv
// Splits one DRAM read request into 4 KB-safe AXI4 INCR bursts
// and streams returned beats out. Ports: request (addr/len/en),
// response (data/valid), status (busy/error/overrun), AXI AR+R.
module dram_axi_read_master
  import dram_axi_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH    = 1
) (
  input  logic                       m_axi_aclk,
  input  logic                       m_axi_aresetn,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       dram_read_error,
  output logic                       dram_read_overrun,
  output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  output logic                       m_axi_arlock,
  output logic [3:0]                 m_axi_arqos,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int BYTES = DRAM_DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int AW    = DRAM_ADDR_WIDTH;

  localparam logic [AW-1:0] ALIGN_MASK =
    {{(AW-SIZE){1'b1}}, {SIZE{1'b0}}};

  state_e                       state_q, state_d;
  logic [AW-1:0]                cur_addr_q, cur_addr_d;
  logic [8:0]                   remaining_q, remaining_d;
  logic [7:0]                   beat_cnt_q, beat_cnt_d;
  logic [DRAM_DATA_WIDTH-1:0]   data_q, data_d;
  logic                         valid_q, valid_d;
  logic                         err_q, err_d;
  logic                         ovr_q, ovr_d;

  logic [12:0] span;
  logic [12:0] to_bound;
  logic [8:0]  beats;
  logic [8:0]  beats_m1;
  logic        in_addr;

  // Beats left before the next 4 KB line; always >= 1.
  always_comb begin
    span     = 13'(BOUNDARY_BYTES) - {1'b0, cur_addr_q[11:0]};
    to_bound = span >> SIZE;
    beats    = ({4'd0, remaining_q} < to_bound) ?
               remaining_q : to_bound[8:0];
    beats_m1 = beats - 9'd1;
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = err_q;
    ovr_d       = ovr_q | (dram_read_en & (state_q != S_IDLE));
    unique case (state_q)
      S_IDLE: begin
        if (dram_read_en) begin
          cur_addr_d  = dram_read_addr & ALIGN_MASK;
          remaining_d = {1'b0, dram_read_len} + 9'd1;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi_arready) begin
          remaining_d = remaining_q - beats;
          cur_addr_d  = cur_addr_q + (AW'(beats) << SIZE);
          beat_cnt_d  = beats_m1[7:0];
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (m_axi_rvalid) begin
          data_d  = m_axi_rdata;
          valid_d = 1'b1;
          if (m_axi_rresp != RESP_OKAY) err_d = 1'b1;
          if (m_axi_rlast) begin
            if (beat_cnt_q != 8'd0) err_d = 1'b1;
            state_d = (remaining_q != 9'd0) ? S_ADDR : S_IDLE;
          end else if (beat_cnt_q == 8'd0) begin
            // Burst overran its length: flag it, keep waiting for rlast.
            err_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign in_addr = (state_q == S_ADDR);

  // AR fields are held at zero outside ADDR so reset leaves them 0.
  assign m_axi_arvalid = in_addr;
  assign m_axi_araddr  = in_addr ? cur_addr_q : '0;
  assign m_axi_arlen   = in_addr ? beats_m1[7:0] : 8'd0;
  assign m_axi_arsize  = in_addr ? 3'(SIZE) : 3'd0;
  assign m_axi_arburst = in_addr ? BURST_INCR : 2'b00;
  assign m_axi_arid    = '0;
  assign m_axi_arcache = ARCACHE_DEF;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_rready  = (state_q == S_DATA);

  assign dram_read_busy       = (state_q != S_IDLE);
  assign dram_read_data       = data_q;
  assign dram_read_data_valid = valid_q;
  assign dram_read_error      = err_q;
  assign dram_read_overrun    = ovr_q;

endmodule

// File: tb/tb_dram_axi_read_master.sv
// Scoreboard bench for dram_axi_read_master with a simple
// AXI slave memory model and randomized gaps/delays.
module tb_dram_axi_read_master;

  localparam int AW    = 39;
  localparam int DW    = 128;
  localparam int IW    = 1;
  localparam int BYTES = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] dram_read_addr = '0;
  logic [7:0]    dram_read_len = '0;
  logic          dram_read_en = 1'b0;
  logic          busy;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;
  logic          rd_ovr;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arlock;
  logic [3:0]    arqos;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;

  always #5 clk = ~clk;

  dram_axi_read_master #(
    .DRAM_ADDR_WIDTH(AW),
    .DRAM_DATA_WIDTH(DW),
    .AXI_ID_WIDTH(IW)
  ) dut (
    .m_axi_aclk(clk),
    .m_axi_aresetn(rst_n),
    .dram_read_addr(dram_read_addr),
    .dram_read_len(dram_read_len),
    .dram_read_en(dram_read_en),
    .dram_read_busy(busy),
    .dram_read_data(rd_data),
    .dram_read_data_valid(rd_valid),
    .dram_read_error(rd_err),
    .dram_read_overrun(rd_ovr),
    .m_axi_arid(arid),
    .m_axi_araddr(araddr),
    .m_axi_arlen(arlen),
    .m_axi_arsize(arsize),
    .m_axi_arburst(arburst),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_arcache(arcache),
    .m_axi_arprot(arprot),
    .m_axi_arlock(arlock),
    .m_axi_arqos(arqos),
    .m_axi_rdata(rdata),
    .m_axi_rresp(rresp),
    .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  logic [DW-1:0] exp_data[$];
  ar_t           exp_ar[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            exp_err = 0;
  bit            exp_ovr = 0;
  int            exp_total = 0;
  logic [AW-1:0] err_addr = '1;
  int            ar_delay_force = -1;
  int            gap_max = 0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0],
            a[31:0] + 32'h1357_9BDF, a[31:0]};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // AXI slave memory: one burst at a time, random gaps.
  ar_t           sq[$];
  ar_t           s_b;
  ar_t           hs_ar;
  logic [AW-1:0] s_addr;
  int            s_left;
  bit            s_active;
  bit            ar_hs_p;
  bit            r_hs_p;
  int            ar_cnt;
  int            ar_dly;

  initial begin
    s_active = 0; ar_hs_p = 0; r_hs_p = 0;
    ar_cnt = 0; ar_dly = 0; s_left = 0; s_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sq.delete();
        s_active = 0; ar_hs_p = 0; r_hs_p = 0;
        ar_cnt = 0; arready = 0; rvalid = 0; rlast = 0;
        continue;
      end
      if (ar_hs_p) sq.push_back(hs_ar);
      if (r_hs_p) begin
        s_addr = s_addr + AW'(BYTES);
        s_left--;
        if (s_left == 0) s_active = 0;
      end
      if (!s_active && sq.size() > 0) begin
        s_b = sq.pop_front();
        s_addr = s_b.addr;
        s_left = int'(s_b.len) + 1;
        s_active = 1;
      end
      arready = arvalid && (ar_cnt >= ar_dly);
      if (arvalid && !arready) ar_cnt++;
      ar_hs_p = arvalid && arready;
      if (ar_hs_p) begin
        hs_ar = '{araddr, arlen};
        ar_cnt = 0;
        ar_dly = (ar_delay_force >= 0) ? ar_delay_force
                                       : int'($urandom_range(0, 3));
      end
      if (s_active && $urandom_range(0, gap_max) == 0) begin
        rvalid = 1;
        rdata = pat(s_addr);
        rresp = (s_addr == err_addr) ? 2'b10 : 2'b00;
        rlast = (s_left == 1);
      end else begin
        rvalid = 0;
        rlast = 0;
        rresp = 2'b00;
        rdata = {4{$urandom}};
      end
      r_hs_p = rvalid && rready;
    end
  end

  // Monitor: samples 1 time unit before each rising edge.
  bit                  chk_idle = 0;
  bit                  chk_start = 0;
  bit                  prev_stall = 0;
  logic [AW+12:0]      prev_f;
  int                  mon_beats = 0;
  ar_t                 m_ar;

  initial begin
    prev_f = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        chk_idle = 0; chk_start = 0; prev_stall = 0;
        continue;
      end
      if (chk_idle) begin
        chk("busy_drop", DW'(busy), DW'(0));
        chk("last_valid", DW'(rd_valid), DW'(1));
        chk_idle = 0;
      end
      if (chk_start) begin
        chk("start_busy_arvalid", DW'({busy, arvalid}), DW'(2'b11));
        chk_start = 0;
      end
      if (prev_stall)
        chk("ar_stable",
            DW'({arvalid, araddr, arlen, arsize, arburst}),
            DW'({1'b1, prev_f}));
      if (rd_valid) begin
        if (exp_data.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat: got %h want none", rd_data);
        end else begin
          chk("beat_data", rd_data, exp_data.pop_front());
        end
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_ar: got %h want none", araddr);
        end else begin
          m_ar = exp_ar.pop_front();
          chk("ar_addr_len", DW'({araddr, arlen}), DW'(m_ar));
          chk("ar_size_burst", DW'({arsize, arburst}),
              DW'({3'd4, 2'b01}));
        end
      end
      prev_stall = arvalid && !arready;
      prev_f = {araddr, arlen, arsize, arburst};
      if (dram_read_en && !busy) begin
        chk_start = 1;
        mon_beats = 0;
      end
      if (rvalid && rready) begin
        mon_beats++;
        if (rlast && mon_beats == exp_total) chk_idle = 1;
      end
    end
  end

  task automatic issue(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    logic [AW-1:0] a0;
    int left;
    int tb;
    int b;
    @(negedge clk);
    a0 = addr & ~AW'(BYTES - 1);
    for (int i = 0; i <= len; i++)
      exp_data.push_back(pat(a0 + AW'(i * BYTES)));
    a = a0;
    left = len + 1;
    while (left > 0) begin
      tb = (4096 - int'(a[11:0])) / BYTES;
      b = (left < tb) ? left : tb;
      exp_ar.push_back('{a, 8'(b - 1)});
      a = a + AW'(b * BYTES);
      left -= b;
    end
    if (err_addr >= a0 && err_addr < a0 + AW'((len + 1) * BYTES))
      exp_err = 1;
    exp_total = len + 1;
    dram_read_addr = addr;
    dram_read_len = 8'(len);
    dram_read_en = 1;
    @(negedge clk);
    dram_read_en = 0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while ((busy || exp_data.size() != 0) && c < 6000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 6000) chk("done_timeout", DW'(1), DW'(0));
    repeat (2) @(negedge clk);
    chk("error_flag", DW'(rd_err), DW'(exp_err));
    chk("overrun_flag", DW'(rd_ovr), DW'(exp_ovr));
    chk("ar_left", DW'(exp_ar.size()), DW'(0));
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_ctrl", DW'({busy, rd_valid, arvalid, rready, rd_err, rd_ovr}),
        DW'(0));
    chk("rst_data", rd_data, DW'(0));
    chk("rst_ar", DW'({araddr, arlen, arsize, arburst, arid}), DW'(0));
    chk("rst_attr", DW'({arcache, arprot, arlock, arqos}),
        DW'({4'b0011, 3'b000, 1'b0, 4'd0}));
    repeat (3) @(negedge clk);
    #1 rst_n = 1;

    issue(39'h00_0010_0000, 15);
    wait_done();

    issue(39'h00_0000_0F80, 255);
    wait_done();

    ar_delay_force = 5;
    issue(39'h00_2000_0040, 3);
    wait_done();
    ar_delay_force = -1;

    gap_max = 3;
    err_addr = 39'h00_0030_0000 + 39'd48;
    issue(39'h00_0030_0000, 9);
    wait_done();
    err_addr = '1;

    gap_max = 1;
    issue(39'h00_0040_0000, 31);
    repeat (4) @(negedge clk);
    chk("busy_at_overrun", DW'(busy), DW'(1));
    dram_read_addr = 39'h00_0777_0000;
    dram_read_len = 8'd3;
    dram_read_en = 1;
    exp_ovr = 1;
    @(negedge clk);
    dram_read_en = 0;
    wait_done();

    gap_max = 0;
    issue(39'h00_0050_0000, 63);
    repeat (10) @(negedge clk);
    chk("rready_before_rst", DW'(rready), DW'(1));
    #2 rst_n = 0;
    #1;
    chk("arst_ctrl", DW'({busy, rd_valid, arvalid, rready, rd_err, rd_ovr}),
        DW'(0));
    chk("arst_data", rd_data, DW'(0));
    exp_data.delete();
    exp_ar.delete();
    exp_err = 0;
    exp_ovr = 0;
    exp_total = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    issue(39'h00_0060_0FC0, 40);
    wait_done();

    for (int k = 0; k < 8; k++) begin
      gap_max = int'($urandom_range(0, 2));
      issue(AW'($urandom & 32'h0FFF_FFFF), int'($urandom_range(0, 255)));
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
